// File: rtl/up_tpl_regmap_hub.sv
// up_tpl_regmap_hub: routes single-outstanding up-bus transactions from one
// up_axi master port to NUM_SLAVES register banks. Each slave owns a
// 2^SLAVE_SHIFT word window. Acks are tracked per transaction. Slaves that
// never answer, and unmapped addresses, complete with ERR_DATA and up_err.
//
// Ports:
//   up_clk, up_rstn            clock, async active-low reset
//   up_wreq/up_waddr/up_wdata  master write request; up_wack completes it
//   up_rreq/up_raddr           master read request; up_rack/up_rdata complete it
//   up_wreq_s/up_rreq_s        one-hot per-slave request pulses
//   up_waddr_s/up_wdata_s/up_raddr_s  registered payload shared by all slaves
//   up_wack_s/up_rack_s/up_rdata_s    per-slave completions (slave i at [32*i+:32])
//   up_err, up_err_count       error pulse and saturating error counter
//   up_overflow(_clr)          sticky "request dropped while busy" flag
module up_tpl_regmap_hub #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned SLAVE_SHIFT    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_DEAD
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic                       up_wreq,
  input  logic [ADDR_WIDTH-1:0]      up_waddr,
  input  logic [31:0]                up_wdata,
  output logic                       up_wack,
  input  logic                       up_rreq,
  input  logic [ADDR_WIDTH-1:0]      up_raddr,
  output logic [31:0]                up_rdata,
  output logic                       up_rack,
  output logic [NUM_SLAVES-1:0]      up_wreq_s,
  output logic [ADDR_WIDTH-1:0]      up_waddr_s,
  output logic [31:0]                up_wdata_s,
  input  logic [NUM_SLAVES-1:0]      up_wack_s,
  output logic [NUM_SLAVES-1:0]      up_rreq_s,
  output logic [ADDR_WIDTH-1:0]      up_raddr_s,
  input  logic [NUM_SLAVES*32-1:0]   up_rdata_s,
  input  logic [NUM_SLAVES-1:0]      up_rack_s,
  output logic                       up_err,
  output logic [15:0]                up_err_count,
  output logic                       up_overflow,
  input  logic                       up_overflow_clr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = ADDR_WIDTH - SLAVE_SHIFT;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  // Last WAIT cycle: the response lands TIMEOUT_CYCLES+1 cycles after the request.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // One-hot slave select for an address; all-zero when the address is unmapped.
  function automatic logic [NUM_SLAVES-1:0] slave_sel(input logic [ADDR_WIDTH-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(a >> SLAVE_SHIFT);
    slave_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) slave_sel[i] = 1'b1;
    end
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic                    pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]   waddr_s_q, waddr_s_d;
  logic [ADDR_WIDTH-1:0]   raddr_s_q, raddr_s_d;
  logic [DATA_W-1:0]       wdata_s_q, wdata_s_d;
  logic [NUM_SLAVES-1:0]   wreq_s_q, wreq_s_d;
  logic [NUM_SLAVES-1:0]   rreq_s_q, rreq_s_d;
  logic                    wack_q, wack_d;
  logic                    rack_q, rack_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic                    ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0]   cur_addr_c;
  logic [NUM_SLAVES-1:0]   cur_sel_c;
  logic                    cur_ack_c;
  logic [DATA_W-1:0]       cur_rdata_c;
  logic                    done_c;
  logic                    done_err_c;
  logic                    ovf_set_c;

  // Route completion signals of the slave owning the in-flight transaction.
  always_comb begin
    cur_addr_c  = is_wr_q ? waddr_s_q : raddr_s_q;
    cur_sel_c   = slave_sel(cur_addr_c);
    cur_ack_c   = is_wr_q ? |(up_wack_s & cur_sel_c) : |(up_rack_s & cur_sel_c);
    cur_rdata_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cur_sel_c[i]) cur_rdata_c = up_rdata_s[DATA_W*i +: DATA_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    pend_d     = pend_q;
    waddr_s_d  = waddr_s_q;
    wdata_s_d  = wdata_s_q;
    raddr_s_d  = raddr_s_q;
    wreq_s_d   = '0;
    rreq_s_d   = '0;
    wack_d     = 1'b0;
    rack_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    err_cnt_d  = err_cnt_q;
    ovf_d      = ovf_q;
    done_c     = 1'b0;
    done_err_c = 1'b0;
    ovf_set_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous read parks in the pending slot behind the write.
        if (up_wreq) begin
          waddr_s_d = up_waddr;
          wdata_s_d = up_wdata;
          is_wr_d   = 1'b1;
          pend_d    = up_rreq;
          wreq_s_d  = slave_sel(up_waddr);
          if (up_rreq) raddr_s_d = up_raddr;
          state_d   = ST_ISSUE;
        end else if (up_rreq) begin
          raddr_s_d = up_raddr;
          is_wr_d   = 1'b0;
          rreq_s_d  = slave_sel(up_raddr);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ovf_set_c = up_wreq | up_rreq;
        cnt_d     = '0;
        if (|cur_sel_c) begin
          state_d = ST_WAIT;
        end else begin
          done_c     = 1'b1;
          done_err_c = 1'b1;
        end
      end
      ST_WAIT: begin
        ovf_set_c = up_wreq | up_rreq;
        // An ack in the final wait cycle beats the timeout.
        if (cur_ack_c) begin
          done_c = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          done_c     = 1'b1;
          done_err_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        ovf_set_c = up_wreq | up_rreq;
        if (pend_q) begin
          pend_d   = 1'b0;
          is_wr_d  = 1'b0;
          rreq_s_d = slave_sel(raddr_s_q);
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion: master ack, read data capture and error accounting.
    if (done_c) begin
      state_d = ST_RESP;
      if (is_wr_q) begin
        wack_d = 1'b1;
      end else begin
        rack_d  = 1'b1;
        rdata_d = done_err_c ? ERR_DATA : cur_rdata_c;
      end
      if (done_err_c) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    // Sticky overflow; a set in the same cycle as a clear wins.
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (up_overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      pend_q    <= 1'b0;
      waddr_s_q <= '0;
      wdata_s_q <= '0;
      raddr_s_q <= '0;
      wreq_s_q  <= '0;
      rreq_s_q  <= '0;
      wack_q    <= 1'b0;
      rack_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      pend_q    <= pend_d;
      waddr_s_q <= waddr_s_d;
      wdata_s_q <= wdata_s_d;
      raddr_s_q <= raddr_s_d;
      wreq_s_q  <= wreq_s_d;
      rreq_s_q  <= rreq_s_d;
      wack_q    <= wack_d;
      rack_q    <= rack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign up_wack      = wack_q;
  assign up_rack      = rack_q;
  assign up_rdata     = rdata_q;
  assign up_wreq_s    = wreq_s_q;
  assign up_rreq_s    = rreq_s_q;
  assign up_waddr_s   = waddr_s_q;
  assign up_wdata_s   = wdata_s_q;
  assign up_raddr_s   = raddr_s_q;
  assign up_err       = err_q;
  assign up_err_count = err_cnt_q;
  assign up_overflow  = ovf_q;

endmodule

// File: tb/tb_up_tpl_regmap_hub.sv
// Bench for up_tpl_regmap_hub: directed and randomized transactions checked
// against a latency/response model built from the hub's address-map rules.
module tb_up_tpl_regmap_hub;

  localparam int unsigned NS  = 4;
  localparam int unsigned AW  = 14;
  localparam int unsigned TMO = 64;
  localparam logic [31:0] ERR = 32'hDEAD_DEAD;

  logic              clk;
  logic              rstn;
  logic              up_wreq;
  logic [AW-1:0]     up_waddr;
  logic [31:0]       up_wdata;
  logic              up_wack;
  logic              up_rreq;
  logic [AW-1:0]     up_raddr;
  logic [31:0]       up_rdata;
  logic              up_rack;
  logic [NS-1:0]     up_wreq_s;
  logic [AW-1:0]     up_waddr_s;
  logic [31:0]       up_wdata_s;
  logic [NS-1:0]     up_wack_s;
  logic [NS-1:0]     up_rreq_s;
  logic [AW-1:0]     up_raddr_s;
  logic [NS*32-1:0]  up_rdata_s;
  logic [NS-1:0]     up_rack_s;
  logic              up_err;
  logic [15:0]       up_err_count;
  logic              up_overflow;
  logic              up_overflow_clr;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          model_errcnt = 0;
  logic [31:0] model_rdata  = '0;

  up_tpl_regmap_hub #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .SLAVE_SHIFT(8),
    .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)
  ) dut (
    .up_clk(clk), .up_rstn(rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .up_wreq_s(up_wreq_s), .up_waddr_s(up_waddr_s), .up_wdata_s(up_wdata_s),
    .up_wack_s(up_wack_s), .up_rreq_s(up_rreq_s), .up_raddr_s(up_raddr_s),
    .up_rdata_s(up_rdata_s), .up_rack_s(up_rack_s),
    .up_err(up_err), .up_err_count(up_err_count),
    .up_overflow(up_overflow), .up_overflow_clr(up_overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: address map and response timing of one transaction.
  function automatic int slave_of(input logic [AW-1:0] a);
    return int'(a) / 256;
  endfunction

  function automatic bit is_mapped(input logic [AW-1:0] a);
    return slave_of(a) < int'(NS);
  endfunction

  // k = cycles from slave request to slave ack; out of window means no ack.
  function automatic bit ack_in_window(input int k);
    return (k >= 1) && (k <= int'(TMO) - 1);
  endfunction

  function automatic int exp_latency(input logic [AW-1:0] a, input int k);
    if (!is_mapped(a)) return 2;
    if (ack_in_window(k)) return 2 + k;
    return int'(TMO) + 1;
  endfunction

  function automatic bit exp_error(input logic [AW-1:0] a, input int k);
    return !is_mapped(a) || !ack_in_window(k);
  endfunction

  task automatic idle_inputs();
    up_wreq = 1'b0; up_rreq = 1'b0;
    up_wack_s = '0; up_rack_s = '0;
    up_overflow_clr = 1'b0;
    up_rdata_s = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One master transaction with an emulated slave; called at a negedge in IDLE.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input int k, input logic [31:0] sd, input bit busy_poke);
    int            lat   = exp_latency(addr, k);
    bit            err   = exp_error(addr, k);
    int            sidx  = slave_of(addr);
    int            seen  = 0;
    bit            wrong = 1'b0;
    logic [31:0]   seen_rdata = '0;
    logic          seen_err   = 1'b0;
    logic [NS-1:0] exp_sel    = '0;
    logic [31:0]   exp_rdata;
    if (is_mapped(addr)) exp_sel[sidx] = 1'b1;
    if (wr) begin
      up_wreq = 1'b1; up_waddr = addr; up_wdata = wd;
    end else begin
      up_rreq = 1'b1; up_raddr = addr;
    end
    for (int c = 1; c <= int'(TMO) + 4; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 1) begin
        chk("req_s_sel", wr ? up_wreq_s : up_rreq_s, exp_sel);
        chk("req_s_other", wr ? up_rreq_s : up_wreq_s, '0);
        if (wr) begin
          chk("waddr_s", up_waddr_s, addr);
          chk("wdata_s", up_wdata_s, wd);
        end else begin
          chk("raddr_s", up_raddr_s, addr);
        end
      end
      if (c == 2) chk("req_s_one_cycle", {up_wreq_s, up_rreq_s}, '0);
      if (wr ? up_rack : up_wack) wrong = 1'b1;
      if (seen == 0 && (wr ? up_wack : up_rack)) begin
        seen = c; seen_rdata = up_rdata; seen_err = up_err;
      end
      if (seen != 0 && c == seen + 1) begin
        chk("ack_single_pulse", {up_wack, up_rack, up_err}, '0);
        chk("no_extra_req_s", {up_wreq_s, up_rreq_s}, '0);
        break;
      end
      if (is_mapped(addr) && c == 1 + k) begin
        if (wr) up_wack_s[sidx] = 1'b1;
        else begin
          up_rack_s[sidx] = 1'b1;
          up_rdata_s[32*sidx +: 32] = sd;
        end
      end
      // Ack from a non-selected slave must be ignored.
      if (c == 2 && k != 1) begin
        up_wack_s[(sidx + 3) % int'(NS)] = 1'b1;
        up_rack_s[(sidx + 3) % int'(NS)] = 1'b1;
      end
      if (busy_poke && c == 2) begin
        up_rreq = 1'b1; up_raddr = AW'($urandom_range(0, 1023));
        up_overflow_clr = 1'b1;
      end
    end
    exp_rdata = wr ? model_rdata : (err ? ERR : sd);
    if (!wr) model_rdata = exp_rdata;
    if (err && model_errcnt < 65535) model_errcnt++;
    chk("ack_latency", 64'(seen), 64'(lat));
    chk("wrong_ack", 64'(wrong), 0);
    chk("rdata", seen_rdata, exp_rdata);
    chk("err_pulse", seen_err, err);
    chk("err_count", up_err_count, 64'(model_errcnt));
    chk("overflow", up_overflow, busy_poke);
    if (busy_poke) begin
      up_overflow_clr = 1'b1;
      @(negedge clk);
      up_overflow_clr = 1'b0;
      chk("overflow_clr", up_overflow, 0);
    end
  endtask

  initial begin
    bit            wr;
    int            k;
    int            r;
    logic [AW-1:0] addr;
    rstn = 1'b0;
    up_waddr = '0; up_wdata = '0; up_raddr = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_acks", {up_wack, up_rack, up_err, up_overflow}, '0);
    chk("reset_req_s", {up_wreq_s, up_rreq_s}, '0);
    chk("reset_rdata", up_rdata, 0);
    chk("reset_payload", {up_waddr_s, up_raddr_s, up_wdata_s}, '0);
    chk("reset_err_count", up_err_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 14'h0105, 32'h0, 1, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 14'h0203, 32'hA5A5_A5A5, 3, 32'h0, 1'b0);
    run_txn(1'b0, 14'h0400, 32'h0, 1, 32'h0, 1'b0);
    run_txn(1'b0, 14'h0007, 32'h0, 1000, 32'h0, 1'b0);
    run_txn(1'b0, 14'h0011, 32'h0, int'(TMO) - 1, 32'h0BAD_F00D, 1'b0);
    run_txn(1'b1, 14'h03FF, 32'h1111_2222, 2, 32'h0, 1'b1);

    // Simultaneous write + read, with a dropped third request during WAIT.
    up_wreq = 1'b1; up_waddr = 14'h0010; up_wdata = 32'hCAFE_0001;
    up_rreq = 1'b1; up_raddr = 14'h0110;
    @(negedge clk); idle_inputs();
    chk("pend_wreq_s", up_wreq_s, 4'b0001);
    chk("pend_rreq_s_idle", up_rreq_s, 4'b0000);
    @(negedge clk); idle_inputs();
    up_wack_s[0] = 1'b1;
    up_wreq = 1'b1; up_waddr = 14'h0301; up_wdata = 32'h7777_7777;
    @(negedge clk); idle_inputs();
    chk("pend_wack", {up_wack, up_rack, up_err}, 3'b100);
    chk("pend_overflow_set", up_overflow, 1);
    @(negedge clk); idle_inputs();
    chk("pend_read_issue", {up_wreq_s, up_rreq_s}, 8'b0000_0010);
    chk("pend_raddr_s", up_raddr_s, 14'h0110);
    chk("pend_waddr_kept", {up_waddr_s, up_wdata_s}, {14'h0010, 32'hCAFE_0001});
    @(negedge clk); idle_inputs();
    up_rack_s[1] = 1'b1; up_rdata_s[63:32] = 32'h600D_D00D;
    @(negedge clk); idle_inputs();
    chk("pend_rack", {up_wack, up_rack, up_err}, 3'b010);
    chk("pend_rdata", up_rdata, 32'h600D_D00D);
    model_rdata = 32'h600D_D00D;
    @(negedge clk); idle_inputs();
    chk("pend_no_third", {up_wreq_s, up_rreq_s, up_wack, up_rack}, '0);
    chk("pend_overflow_sticky", up_overflow, 1);
    up_overflow_clr = 1'b1;
    @(negedge clk); idle_inputs();
    chk("pend_overflow_clr", up_overflow, 0);

    // Randomized traffic, including unmapped windows and timeouts.
    for (int n = 0; n < 30; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 5) * 256 + $urandom_range(0, 255));
      r    = int'($urandom_range(0, 9));
      if (r < 8) k = int'($urandom_range(1, 6));
      else if (r == 8) k = int'($urandom_range(60, 63));
      else k = 500;
      run_txn(wr, addr, $urandom, k, $urandom, ($urandom_range(0, 3) == 0));
    end

    // Reset while a read waits on slave 0.
    up_rreq = 1'b1; up_raddr = 14'h0020;
    @(negedge clk); idle_inputs();
    @(negedge clk); idle_inputs();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_wait_acks", {up_wack, up_rack, up_err, up_overflow}, '0);
    chk("rst_wait_req_s", {up_wreq_s, up_rreq_s}, '0);
    chk("rst_wait_data", {up_rdata, up_waddr_s, up_raddr_s, up_wdata_s}, '0);
    chk("rst_wait_err_count", up_err_count, 0);
    model_errcnt = 0;
    model_rdata  = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 14'h0242, 32'h0, 2, 32'h5EED_1234, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
